// File: rtl/lsu_subword.sv
// lsu_subword: byte/halfword/word load-store unit in front of a word-wide memory
// with a 1-cycle registered read and no byte enables.
module lsu_subword #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] dmem_addr_o,
  input  logic [31:0] dmem_rd_data_i,
  output logic [31:0] dmem_wr_data_o,
  output logic        dmem_read_o,
  output logic        dmem_write_o
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, CAP = 2'd2, WR = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic        accept, req_err;
  logic [31:0] off, sh, ext, wmask, merged;
  logic [4:0]  shamt;
  assign req_ready_o = (state_q == IDLE) & rst_ni;
  assign accept      = req_valid_i & req_ready_o;
  assign off         = req_addr_i - BASE_ADDR;
  assign req_err = (req_funct3_i[1:0] == 2'b11) | (req_funct3_i[2:1] == 2'b11)
                 | (req_we_i & req_funct3_i[2])
                 | ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0])
                 | ((req_funct3_i[1:0] == 2'b10) & (|req_addr_i[1:0]))
                 | (off >= SIZE_BYTES);
  // data_q holds store data until CAP, then the merged word for the write-back
  assign shamt  = {addr_q[1:0], 3'b000};
  assign sh     = dmem_rd_data_i >> shamt;
  assign ext    = f3_q[1] ? sh
                : f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]}
                :           {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
  assign wmask  = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
  assign merged = (dmem_rd_data_i & ~wmask) | ((data_q << shamt) & wmask);
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    f3_d        = f3_q;
    we_d        = we_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        addr_d      = req_addr_i;
        f3_d        = req_funct3_i;
        we_d        = req_we_i;
        data_d      = req_wdata_i;
        rsp_valid_d = req_err;
        rsp_err_d   = req_err;
        rdata_d     = req_err ? 32'h0 : rdata_q;
        state_d     = req_err ? IDLE : (req_we_i & req_funct3_i[1]) ? WR : RD;
      end
      RD: state_d = CAP;
      CAP: begin
        data_d      = we_q ? merged : data_q;
        rdata_d     = we_q ? rdata_q : ext;
        rsp_valid_d = ~we_q;
        state_d     = we_q ? WR : IDLE;
      end
      default: begin
        rdata_d     = 32'h0;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      f3_q        <= 3'h0;
      we_q        <= 1'b0;
      data_q      <= 32'h0;
      rdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_rdata_o    = rdata_q;
  assign dmem_addr_o    = {addr_q[31:2], 2'b00};
  assign dmem_wr_data_o = data_q;
  assign dmem_read_o    = state_q == RD;
  assign dmem_write_o   = state_q == WR;
endmodule
